controle_acumulador: RTL and testbench

CONTROLE_ACUMULADOR -- requirements
Module: controle_acumulador

---
 rtl/controle_acumulador.sv | 118 +++++++++++
 tb/tb_controle_acumulador.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_acumulador.sv
// rtl/controle_acumulador.sv - command FSM driving one-hot op select and enable to an accumulator stage
// Outputs are registered from the current state, so each phase appears one cycle after its state.
module controle_acumulador #(
    parameter int HOLD_CYC = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic [3:0] operand,
    output logic [3:0] A,
    output logic [8:0] in,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] ops_cnt
);

    typedef enum logic [2:0] {IDLE, SETUP, EXEC, HOLD, ERR} state_t;

    state_t     state_q, state_d;
    logic [3:0] opc_q, opc_d;
    logic [3:0] opd_q, opd_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] a_q, a_d;
    logic [8:0] in_q, in_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        opd_d   = opd_q;
        hold_d  = hold_q;
        a_d     = a_q;
        in_d    = in_q;
        en_d    = 1'b0;
        busy_d  = (state_q != IDLE);
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                in_d = 9'd0;
                if (start) begin
                    opc_d   = opcode;
                    opd_d   = operand;
                    state_d = (opcode <= 4'd8) ? SETUP : ERR;
                end
            end
            SETUP: begin
                a_d     = opd_q;
                in_d    = 9'd1 << opc_q;
                state_d = EXEC;
            end
            EXEC: begin
                en_d    = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                hold_d  = 4'd0;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == 4'(HOLD_CYC - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ERR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            opc_q   <= 4'd0;
            opd_q   <= 4'd0;
            hold_q  <= 4'd0;
            a_q     <= 4'd0;
            in_q    <= 9'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            opd_q   <= opd_d;
            hold_q  <= hold_d;
            a_q     <= a_d;
            in_q    <= in_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A       = a_q;
    assign in      = in_q;
    assign en      = en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign ops_cnt = cnt_q;

endmodule

// File: tb/tb_controle_acumulador.sv
// tb/tb_controle_acumulador.sv - self-checking bench for controle_acumulador
module tb_controle_acumulador;

    localparam int HC = 1;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] A;
    logic [8:0] in_o;
    logic       en;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] ops_cnt;

    controle_acumulador #(.HOLD_CYC(HC)) dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .operand(operand),
        .A(A), .in(in_o), .en(en), .busy(busy), .done(done), .err(err), .ops_cnt(ops_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [8:0] inv;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] opd;
        logic [8:0] exp_in;
        logic       legal;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] exp_cnt;
    int         checks = 0;
    int         failures = 0;
    int         en_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every en pulse must match the oldest outstanding legal command.
    always @(negedge clk) begin
        if (!clr) begin
            chk("onehot_inv", 32'($countones(in_o) <= 1 && !(en && in_o == 9'd0)), 32'd1);
            if (en) begin
                en_pulses++;
                if (exp_q.size() == 0) begin
                    chk("spurious_en", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_A", 32'(A), 32'(e.a));
                    chk("sb_in", 32'(in_o), 32'(e.inv));
                    chk("sb_ops_cnt", 32'(ops_cnt), 32'(e.cnt));
                end
            end
        end
    end

    task automatic do_clr();
        clr = 1'b1;
        exp_q.delete();
        exp_cnt = 8'd0;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] opd,
                           input logic [8:0] exp_in, output int lat);
        logic legal;
        legal   = (op <= 4'd8);
        opcode  = op;
        operand = opd;
        start   = 1'b1;
        if (legal) begin
            exp_cnt = exp_cnt + 8'd1;
            exp_q.push_back('{a: opd, inv: exp_in, cnt: exp_cnt});
        end
        tick();
        start = 1'b0;
        lat   = 1;
        while (!(legal ? done : err) && lat < 40) begin
            tick();
            lat++;
        end
        chk("cmd_timeout", 32'(lat < 40), 32'd1);
    endtask

    initial begin
        vec_t       vecs[12];
        int         lat, lat2, base_en;
        logic [7:0] cnt_before;

        vecs[0]  = '{4'd0,  4'd3,  9'h001, 1'b1};
        vecs[1]  = '{4'd1,  4'd15, 9'h002, 1'b1};
        vecs[2]  = '{4'd2,  4'd8,  9'h004, 1'b1};
        vecs[3]  = '{4'd3,  4'd7,  9'h008, 1'b1};
        vecs[4]  = '{4'd4,  4'd0,  9'h010, 1'b1};
        vecs[5]  = '{4'd5,  4'd9,  9'h020, 1'b1};
        vecs[6]  = '{4'd6,  4'd1,  9'h040, 1'b1};
        vecs[7]  = '{4'd7,  4'd12, 9'h080, 1'b1};
        vecs[8]  = '{4'd8,  4'd6,  9'h100, 1'b1};
        vecs[9]  = '{4'd9,  4'd5,  9'h000, 1'b0};
        vecs[10] = '{4'd12, 4'd2,  9'h000, 1'b0};
        vecs[11] = '{4'd15, 4'd4,  9'h000, 1'b0};

        clr = 1'b1; start = 1'b0; opcode = 4'd0; operand = 4'd0; exp_cnt = 8'd0;
        #2;
        chk("rst_A", 32'(A), 32'd0);
        chk("rst_in", 32'(in_o), 32'd0);
        chk("rst_en_busy_done_err", 32'({en, busy, done, err}), 32'd0);
        chk("rst_ops_cnt", 32'(ops_cnt), 32'd0);
        tick();
        clr = 1'b0;

        // Legal command opcode 8 / operand 2, cycle by cycle.
        opcode = 4'd8; operand = 4'd2; start = 1'b1;
        exp_cnt = 8'd1;
        exp_q.push_back('{a: 4'd2, inv: 9'h100, cnt: 8'd1});
        tick();
        start = 1'b0;
        tick();
        chk("c30_A", 32'(A), 32'd2);
        chk("c30_in", 32'(in_o), 32'h100);
        chk("c30_en_pre", 32'(en), 32'd0);
        chk("c30_busy", 32'(busy), 32'd1);
        tick();
        chk("c30_en", 32'(en), 32'd1);
        chk("c30_ops_cnt", 32'(ops_cnt), 32'd1);
        tick();
        chk("c30_en_post", 32'(en), 32'd0);
        chk("c30_done", 32'(done), 32'd1);
        tick();
        chk("c30_done_post", 32'(done), 32'd0);
        chk("c30_in_idle", 32'(in_o), 32'd0);
        chk("c30_A_keep", 32'(A), 32'd2);
        chk("c30_busy_idle", 32'(busy), 32'd0);

        // Table of single commands, legal and illegal.
        for (int i = 0; i < 12; i++) begin
            base_en    = en_pulses;
            cnt_before = ops_cnt;
            run_cmd(vecs[i].op, vecs[i].opd, vecs[i].exp_in, lat);
            if (vecs[i].legal) begin
                chk("vec_latency", 32'(lat), 32'(3 + HC));
            end else begin
                chk("err_latency", 32'(lat), 32'd2);
                chk("err_busy", 32'(busy), 32'd1);
                chk("err_no_en", 32'(en), 32'd0);
                tick();
                chk("err_pulse_len", 32'(err), 32'd0);
                chk("err_busy_len", 32'(busy), 32'd0);
                chk("err_ops_cnt", 32'(ops_cnt), 32'(cnt_before));
                chk("err_en_count", 32'(en_pulses - base_en), 32'd0);
            end
        end

        // Back-to-back: second start issued in the done cycle.
        do_clr();
        base_en = en_pulses;
        run_cmd(4'd0, 4'd3, 9'h001, lat);
        run_cmd(4'd0, 4'd1, 9'h001, lat2);
        chk("b2b_lat1", 32'(lat), 32'(3 + HC));
        chk("b2b_lat2", 32'(lat2), 32'(3 + HC));
        tick();
        chk("b2b_en_count", 32'(en_pulses - base_en), 32'd2);
        chk("b2b_ops_cnt", 32'(ops_cnt), 32'd2);

        // Start held high: one command per IDLE visit (period 3+HC cycles).
        do_clr();
        base_en = en_pulses;
        opcode = 4'd1; operand = 4'd5; start = 1'b1;
        for (int i = 1; i <= 5; i++) exp_q.push_back('{a: 4'd5, inv: 9'h002, cnt: 8'(i)});
        repeat (4 * (3 + HC) + 1) tick();
        start = 1'b0;
        repeat (10) tick();
        chk("hold_en_count", 32'(en_pulses - base_en), 32'd5);
        chk("hold_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("hold_ops_cnt", 32'(ops_cnt), 32'd5);

        // Asynchronous clear while en is high.
        do_clr();
        opcode = 4'd3; operand = 4'd7; start = 1'b1;
        exp_q.push_back('{a: 4'd7, inv: 9'h008, cnt: 8'd1});
        tick();
        start = 1'b0;
        lat = 0;
        while (!en && lat < 20) begin
            tick();
            lat++;
        end
        chk("rexec_en_seen", 32'(en), 32'd1);
        #2;
        clr = 1'b1;
        exp_q.delete();
        exp_cnt = 8'd0;
        #1;
        chk("rexec_en", 32'(en), 32'd0);
        chk("rexec_in", 32'(in_o), 32'd0);
        chk("rexec_A", 32'(A), 32'd0);
        chk("rexec_ops_cnt", 32'(ops_cnt), 32'd0);
        chk("rexec_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        clr = 1'b0;
        run_cmd(4'd2, 4'd4, 9'h004, lat);
        chk("post_clr_lat", 32'(lat), 32'(3 + HC));
        chk("post_clr_ops_cnt", 32'(ops_cnt), 32'd1);

        // Counter wrap after 256 commands.
        do_clr();
        base_en = en_pulses;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            op = 4'(i % 9);
            run_cmd(op, 4'($urandom_range(0, 15)), 9'd1 << op, lat);
        end
        tick();
        chk("wrap_ops_cnt", 32'(ops_cnt), 32'd0);
        chk("wrap_en_count", 32'(en_pulses - base_en), 32'd256);
        chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
